// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit (mdu_seq):
// funct3 op encodings, FSM state enum and the step-counter width helper.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  // Counter must hold the value XLEN itself, hence one bit beyond log2.
  function automatic int mdu_cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/mdu_seq_adder.sv
// (SIZE)-bit adder with carry-in and carry-out, shared by the multiply
// (add) and divide (trial subtract) step of mdu_seq.
module mdu_seq_adder #(
  parameter int SIZE = 65
) (
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  input  logic            i_cin,
  output logic [SIZE-1:0] o_sum,
  output logic            o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SIZE{1'b0}}, i_cin};

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV64M multiply/divide unit, one shift-add or
// restoring shift-subtract step per cycle, fixed latency XLEN+2.
// Optional macro MDU_WORD_OPS_EN adds the 32-bit *W variants (w=1).
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] s1,
  input  logic [XLEN-1:0] s2,
  input  logic            flush,
  output logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] res
);

  localparam int CW = mdu_cnt_w(XLEN);
  localparam logic [CW-1:0]     CNT_FULL = CW'(XLEN);
  localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
  localparam logic [XLEN-1:0]   X_ZERO   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   X_ONES   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   X_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] P_ONE    = {{(2*XLEN-1){1'b0}}, 1'b1};

  mdu_state_t        r_state, w_next;
  logic [2:0]        r_op;
  logic              r_neg_q, r_neg_r, r_dz;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_hi, r_lo, r_mcand, r_res;
  logic              r_ready, r_valid;

  logic              w_s1_signed, w_s2_signed, w_s1_neg, w_s2_neg;
  logic [XLEN-1:0]   w_s1_ext, w_s2_ext, w_s1_abs, w_s2_abs;
  logic [XLEN-1:0]   w_ld_lo, w_ld_mc;
  logic [CW-1:0]     w_ld_cnt;
  logic [XLEN:0]     w_add_a, w_add_b, w_add_sum;
  logic              w_add_cin, w_add_cout;
  logic [XLEN-1:0]   w_step_hi, w_step_lo;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot_fix, w_rem_fix, w_sel, w_res_fix;

  assign w_s1_signed = (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  assign w_s2_signed = (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);

`ifdef MDU_WORD_OPS_EN
  logic w_word, r_word;
  // *W only exists for MUL and the divides; MULH* with w=1 runs full width.
  assign w_word   = w && ((op == MDU_MUL) || op[2]);
  assign w_s1_ext = w_word ? {{(XLEN-32){w_s1_signed & s1[31]}}, s1[31:0]} : s1;
  assign w_s2_ext = w_word ? {{(XLEN-32){w_s2_signed & s2[31]}}, s2[31:0]} : s2;
`else
  logic w_unused_w;
  assign w_unused_w = w;
  assign w_s1_ext   = s1;
  assign w_s2_ext   = s2;
`endif

  assign w_s1_neg = w_s1_signed & w_s1_ext[XLEN-1];
  assign w_s2_neg = w_s2_signed & w_s2_ext[XLEN-1];
  assign w_s1_abs = w_s1_neg ? (~w_s1_ext + X_ONE) : w_s1_ext;
  assign w_s2_abs = w_s2_neg ? (~w_s2_ext + X_ONE) : w_s2_ext;

  // Operand placement at accept: multiplier/dividend into the low half, the other into r_mcand.
  always_comb begin
    w_ld_lo  = op[2] ? w_s1_abs : w_s2_abs;
    w_ld_mc  = op[2] ? w_s2_abs : w_s1_abs;
    w_ld_cnt = CNT_FULL;
`ifdef MDU_WORD_OPS_EN
    if (w_word) begin
      w_ld_cnt = CW'(32);
      // A 32-step divide must see the dividend bits at the top of the shift register.
      if (op[2]) begin
        w_ld_lo = {w_s1_abs[XLEN-33:0], 32'h0000_0000};
      end else begin
        w_ld_lo = w_s2_abs;
      end
    end else begin
      w_ld_cnt = CNT_FULL;
    end
`endif
  end

  // Step operands: add multiplicand to the upper half, or trial-subtract the divisor.
  always_comb begin
    if (r_op[2]) begin
      w_add_a   = {r_hi, r_lo[XLEN-1]};
      w_add_b   = ~{1'b0, r_mcand};
      w_add_cin = 1'b1;
    end else begin
      w_add_a   = {1'b0, r_hi};
      w_add_b   = r_lo[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}};
      w_add_cin = 1'b0;
    end
  end

  mdu_seq_adder #(.SIZE(XLEN + 1)) u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  // Next shift-register contents; carry-out high means no borrow, so the subtraction is kept.
  always_comb begin
    if (r_op[2]) begin
      w_step_hi = w_add_cout ? w_add_sum[XLEN-1:0] : w_add_a[XLEN-1:0];
      w_step_lo = {r_lo[XLEN-2:0], w_add_cout};
    end else begin
      w_step_hi = w_add_sum[XLEN:1];
      w_step_lo = {w_add_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign fix and result select. Divide-by-zero remainder and signed
  // overflow (MIN / -1) both fall out of the magnitude datapath plus
  // sign fix; only the divide-by-zero quotient needs an override.
  always_comb begin
    w_prod_fix = r_neg_q ? (~{r_hi, r_lo} + P_ONE) : {r_hi, r_lo};
    w_quot_fix = r_dz ? X_ONES : (r_neg_q ? (~r_lo + X_ONE) : r_lo);
    w_rem_fix  = r_neg_r ? (~r_hi + X_ONE) : r_hi;
    case (r_op)
      MDU_MUL:                        w_sel = w_prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_sel = w_prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              w_sel = w_quot_fix;
      MDU_REM, MDU_REMU:              w_sel = w_rem_fix;
      default:                        w_sel = X_ZERO;
    endcase
`ifdef MDU_WORD_OPS_EN
    // After 32 multiply steps the low product word sits at the top of r_lo.
    if (r_word) begin
      if (r_op == MDU_MUL) begin
        w_res_fix = {{(XLEN-32){r_lo[XLEN-1]}}, r_lo[XLEN-1 -: 32]};
      end else begin
        w_res_fix = {{(XLEN-32){w_sel[31]}}, w_sel[31:0]};
      end
    end else begin
      w_res_fix = w_sel;
    end
`else
    w_res_fix = w_sel;
`endif
  end

  // Next-state logic; flush always returns to IDLE and beats a same-cycle start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (start && !flush) ? S_CALC : S_IDLE;
      S_CALC:  w_next = flush ? S_IDLE : ((r_cnt == CNT_ONE) ? S_FIX : S_CALC);
      S_FIX:   w_next = flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, handshake and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_op    <= 3'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= CNT_ZERO;
      r_hi    <= X_ZERO;
      r_lo    <= X_ZERO;
      r_mcand <= X_ZERO;
      r_res   <= X_ZERO;
`ifdef MDU_WORD_OPS_EN
      r_word  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_valid <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_op    <= op;
            r_neg_q <= w_s1_neg ^ w_s2_neg;
            r_neg_r <= w_s1_neg;
            r_dz    <= (w_s2_ext == X_ZERO);
            r_cnt   <= w_ld_cnt;
            r_hi    <= X_ZERO;
            r_lo    <= w_ld_lo;
            r_mcand <= w_ld_mc;
`ifdef MDU_WORD_OPS_EN
            r_word  <= w_word;
`endif
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_res <= w_res_fix;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign ready = r_ready;
  // flush during DONE must still kill the pulse, so it gates the registered flag.
  assign valid = r_valid & ~flush;
  assign res   = r_res;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq (XLEN=64): directed test-plan steps plus
// a few reference-model operations, expected results held in a scoreboard queue.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int XLEN = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        w = 1'b0;
  logic [63:0] s1 = 64'd0;
  logic [63:0] s2 = 64'd0;
  logic        flush = 1'b0;
  logic        ready, valid;
  logic [63:0] res;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mdu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .w(w),
    .s1(s1), .s2(s2), .flush(flush), .ready(ready), .valid(valid), .res(res)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ref_mdu(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]        pu;
    logic signed [127:0] ps;
    logic signed [63:0]  sa, sb;
    logic [63:0]         r;
    logic                ovf;
    sa  = a;
    sb  = b;
    pu  = {64'd0, a} * {64'd0, b};
    ovf = (a == MINV) && (b == ONES);
    r   = 64'd0;
    case (o)
      3'd0: r = pu[63:0];
      3'd1: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = ps[127:64]; end
      3'd2: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = ps[127:64]; end
      3'd3: r = pu[127:64];
      3'd4: begin
        if (b == 64'd0) r = ONES;
        else if (ovf) r = a;
        else r = sa / sb;
      end
      3'd5: begin
        if (b == 64'd0) r = ONES;
        else r = a / b;
      end
      3'd6: begin
        if (b == 64'd0) r = a;
        else if (ovf) r = 64'd0;
        else r = sa % sb;
      end
      default: begin
        if (b == 64'd0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  // Issue one op, push its expected result, wait (bounded) for valid and score it.
  task automatic run_op(input string tag, input logic [2:0] o, input logic wi,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] expv, input int lat);
    int cyc;
    logic [63:0] e;
    exp_q.push_back(expv);
    op = o; w = wi; s1 = a; s2 = b; start = 1'b1;
    check({tag, "_rdy_idle"}, {63'd0, ready}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, {63'd0, ready}, 64'd0);
    while (valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (valid === 1'b1) begin
      e = exp_q.pop_front();
      check({tag, "_res"}, res, e);
      check({tag, "_lat"}, 64'(cyc), 64'(lat));
      @(posedge clk); #1;
      check({tag, "_pulse"}, {63'd0, valid}, 64'd0);
      check({tag, "_rdy_after"}, {63'd0, ready}, 64'd1);
    end else begin
      exp_q.delete();
      check({tag, "_timeout"}, 64'(cyc), 64'(lat));
    end
  endtask

  // Watch n cycles and require that valid never pulses.
  task automatic no_valid(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) pulses++;
    end
    check(tag, 64'(pulses), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [2:0]  ro;
    logic [63:0] ra, rb;

    // Reset state
    #12;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_res", res, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply family
    run_op("mul", MDU_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    run_op("mulhu", MDU_MULHU, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run_op("mulh", MDU_MULH, 1'b0, ONES, ONES, 64'd0, 66);
    run_op("mulhsu", MDU_MULHSU, 1'b0, ONES, 64'd2, ONES, 66);

    // Divide family
    run_op("div", MDU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_op("rem", MDU_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66);
    run_op("divu", MDU_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66);
    run_op("remu", MDU_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66);

    // Special cases
    run_op("divu_z", MDU_DIVU, 1'b0, 64'd5, 64'd0, ONES, 66);
    run_op("remu_z", MDU_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 66);
    run_op("div_z", MDU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, ONES, 66);
    run_op("div_ovf", MDU_DIV, 1'b0, MINV, ONES, MINV, 66);
    run_op("rem_ovf", MDU_REM, 1'b0, MINV, ONES, 64'd0, 66);

    // Reference-model operations
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(7, 0));
      ra = {$urandom, $urandom};
      rb = (i % 3 == 0) ? 64'($urandom_range(1000, 1)) : {$urandom, $urandom};
      run_op($sformatf("rnd%0d", i), ro, 1'b0, ra, rb, ref_mdu(ro, ra, rb), 66);
    end

    // Flush in CALC cycle 10; a start while busy must be ignored
    op = MDU_MUL; w = 1'b0; s1 = 64'd3; s2 = 64'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      if (cyc == 3) begin
        start = 1'b1; s1 = 64'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", {63'd0, ready}, 64'd1);
    no_valid("flush_novalid", 80);

    // start together with flush in IDLE: the request is dropped
    op = MDU_DIVU; s1 = 64'd100; s2 = 64'd7; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idleflush_ready", {63'd0, ready}, 64'd1);
    no_valid("idleflush_novalid", 80);

    // flush in DONE suppresses the pulse
    op = MDU_DIVU; s1 = 64'd50; s2 = 64'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 66; i++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1;
    check("doneflush_valid", {63'd0, valid}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("doneflush_ready", {63'd0, ready}, 64'd1);
    no_valid("doneflush_novalid", 5);

    // Asynchronous reset mid-CALC, then a fresh op
    op = MDU_DIV; s1 = 64'd1000; s2 = 64'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("arst_ready", {63'd0, ready}, 64'd1);
    check("arst_valid", {63'd0, valid}, 64'd0);
    check("arst_res", res, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst_divu", MDU_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66);

`ifdef MDU_WORD_OPS_EN
    run_op("mulw", MDU_MUL, 1'b1, 64'h0000_0000_8000_0000, 64'd2, 64'd0, 34);
    run_op("divw", MDU_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    run_op("remuw", MDU_REMU, 1'b1, 64'h1234_5678_0000_0064, 64'd7, 64'd2, 34);
    run_op("mulhw_full", MDU_MULHU, 1'b1, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
